// File: rtl/portal_pipe_mux.sv
// portal_pipe_mux: merges NCHAN portal pipe streams onto one output pipe.
// Each channel owns a small FIFO; a round-robin or fixed-priority arbiter
// picks one non-empty FIFO per cycle and forwards its head word tagged with
// the channel index so a downstream demultiplexer can route it back.
module portal_pipe_mux #(
    parameter int NCHAN     = 4,
    parameter int WIDTH     = 96,
    parameter int DEPTH     = 4,
    parameter int PRIO_MODE = 0,
    parameter int ID_W      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NCHAN-1:0]       in_enq__ENA,
    input  logic [NCHAN*WIDTH-1:0] in_enq_v,
    output logic [NCHAN-1:0]       in_enq__RDY,
    output logic                   out_enq__ENA,
    output logic [ID_W+WIDTH-1:0]  out_enq_v,
    input  logic                   out_enq__RDY,
    input  logic                   rule_enable,
    output logic                   rule_ready,
    output logic [NCHAN-1:0]       err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Per-channel FIFO state
    logic [WIDTH-1:0] mem_r   [NCHAN][DEPTH];
    logic [PTR_W-1:0] wptr_r  [NCHAN];
    logic [PTR_W-1:0] rptr_r  [NCHAN];
    logic [CNT_W-1:0] cnt_r   [NCHAN];
    logic [CNT_W-1:0] cnt_nxt_s [NCHAN];
    logic [NCHAN-1:0] full_r;
    logic [NCHAN-1:0] err_r;
    logic [ID_W-1:0]  rr_ptr_r;

    // Arbitration / datapath
    logic [NCHAN-1:0]      req_s;
    logic                  any_req_s;
    logic [ID_W-1:0]       grant_s;
    logic                  found_s;
    logic                  fire_s;
    logic [NCHAN-1:0]      enq_s;
    logic [NCHAN-1:0]      deq_s;
    logic [NCHAN-1:0]      viol_s;
    logic [WIDTH-1:0]      head_s;
    logic [ID_W+WIDTH-1:0] out_v_s;

    // Ready is held low during reset and otherwise reflects registered fullness only
    assign in_enq__RDY  = {NCHAN{nRST}} & ~full_r;
    assign err          = err_r;
    assign rule_ready   = any_req_s & out_enq__RDY;
    assign fire_s       = rule_enable & rule_ready;
    assign out_enq__ENA = fire_s;
    assign out_enq_v    = out_v_s;

    // Request vector and accepted/dropped enqueues per channel
    always_comb begin
        req_s  = '0;
        enq_s  = '0;
        viol_s = '0;
        for (int i = 0; i < NCHAN; i++) begin
            req_s[i]  = (cnt_r[i] != '0);
            enq_s[i]  = in_enq__ENA[i] & in_enq__RDY[i];
            viol_s[i] = in_enq__ENA[i] & ~in_enq__RDY[i];
        end
        any_req_s = |req_s;
    end

    // Grant: first requester scanning upward from rr_ptr (or from 0 in priority mode)
    always_comb begin
        int base_v;
        int idx_v;
        grant_s = '0;
        found_s = 1'b0;
        base_v  = (PRIO_MODE != 0) ? 0 : int'(rr_ptr_r);
        idx_v   = 0;
        for (int k = 0; k < NCHAN; k++) begin
            idx_v = base_v + k;
            if (idx_v >= NCHAN) begin
                idx_v = idx_v - NCHAN;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req_s[idx_v]) begin
                grant_s = idx_v[ID_W-1:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Dequeue select and next occupancy per channel
    always_comb begin
        deq_s = '0;
        for (int i = 0; i < NCHAN; i++) begin
            deq_s[i]     = fire_s && (grant_s == ID_W'(i));
            cnt_nxt_s[i] = cnt_r[i];
            case ({enq_s[i], deq_s[i]})
                2'b10:   cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                2'b01:   cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
                default: cnt_nxt_s[i] = cnt_r[i];
            endcase
        end
    end

    // Output word: tagged head of the granted FIFO, zero when nothing is queued
    always_comb begin
        head_s = mem_r[grant_s][rptr_r[grant_s]];
        if (any_req_s) begin
            out_v_s = {grant_s, head_s};
        end else begin
            out_v_s = '0;
        end
    end

    // FIFO pointers, occupancy, fullness and sticky violation flags
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NCHAN; i++) begin
                wptr_r[i] <= '0;
                rptr_r[i] <= '0;
                cnt_r[i]  <= '0;
            end
            full_r <= '0;
            err_r  <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (enq_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + PTR_W'(1);
                end
                if (deq_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + PTR_W'(1);
                end
                cnt_r[i]  <= cnt_nxt_s[i];
                full_r[i] <= (cnt_nxt_s[i] == CNT_W'(DEPTH));
                if (viol_s[i]) begin
                    err_r[i] <= 1'b1;
                end
            end
        end
    end

    // Round-robin pointer moves past the winner only when a word is forwarded
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_r <= '0;
        end else if (fire_s && (PRIO_MODE == 0)) begin
            if (int'(grant_s) == NCHAN - 1) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= grant_s + ID_W'(1);
            end
        end
    end

    // Payload storage; contents are never visible unless the slot is counted as occupied
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (enq_s[i]) begin
                mem_r[i][wptr_r[i]] <= in_enq_v[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_portal_pipe_mux.sv
// Bench for portal_pipe_mux: one round-robin and one fixed-priority instance,
// a scoreboard queue per instance checked on every forwarded word, a vector
// table for the backpressure/full sequence and hand sequences for the rest.
module tb_portal_pipe_mux;

    localparam int NCHAN = 4;
    localparam int WIDTH = 96;
    localparam int OW    = 2 + WIDTH;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [NCHAN*WIDTH-1:0] in_v;
    logic                   rule_enable;

    logic [NCHAN-1:0] ena_rr, in_rdy_rr, err_rr;
    logic             ordy_rr, oena_rr, rready_rr;
    logic [OW-1:0]    ov_rr;

    logic [NCHAN-1:0] ena_fp, in_rdy_fp, err_fp;
    logic             ordy_fp, oena_fp, rready_fp;
    logic [OW-1:0]    ov_fp;

    int n_pass  = 0;
    int n_total = 0;

    logic [OW-1:0] q_rr[$];
    logic [OW-1:0] q_fp[$];

    typedef struct {
        logic [3:0] ena;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic [3:0] exp_err;
        logic       exp_ena;
    } vec_t;
    vec_t vecs[11];

    always #5 CLK = ~CLK;

    portal_pipe_mux #(.NCHAN(NCHAN), .WIDTH(WIDTH), .DEPTH(4), .PRIO_MODE(0)) u_rr (
        .CLK(CLK), .nRST(nRST),
        .in_enq__ENA(ena_rr), .in_enq_v(in_v), .in_enq__RDY(in_rdy_rr),
        .out_enq__ENA(oena_rr), .out_enq_v(ov_rr), .out_enq__RDY(ordy_rr),
        .rule_enable(rule_enable), .rule_ready(rready_rr), .err(err_rr)
    );

    portal_pipe_mux #(.NCHAN(NCHAN), .WIDTH(WIDTH), .DEPTH(4), .PRIO_MODE(1)) u_fp (
        .CLK(CLK), .nRST(nRST),
        .in_enq__ENA(ena_fp), .in_enq_v(in_v), .in_enq__RDY(in_rdy_fp),
        .out_enq__ENA(oena_fp), .out_enq_v(ov_fp), .out_enq__RDY(ordy_fp),
        .rule_enable(rule_enable), .rule_ready(rready_fp), .err(err_fp)
    );

    function automatic logic [WIDTH-1:0] mk(input logic [7:0] tag, input int n);
        return {tag, 56'h0, 32'(n)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every forwarded word must match the head of the expected queue
    always @(negedge CLK) begin
        if (oena_rr === 1'b1) begin
            if (q_rr.size() == 0) begin
                n_total++;
                $display("FAIL rr_unexpected_word: got %h expected no output", ov_rr);
            end else begin
                check("rr_word", 128'(ov_rr), 128'(q_rr.pop_front()));
            end
        end
        if (oena_fp === 1'b1) begin
            if (q_fp.size() == 0) begin
                n_total++;
                $display("FAIL fp_unexpected_word: got %h expected no output", ov_fp);
            end else begin
                check("fp_word", 128'(ov_fp), 128'(q_fp.pop_front()));
            end
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        int cnt;
        int sent;
        logic tog;

        nRST = 1'b0; in_v = '0; rule_enable = 1'b1;
        ena_rr = '0; ordy_rr = 1'b1; ena_fp = '0; ordy_fp = 1'b1;

        vecs[0]  = '{4'b0010, 1'b0, 4'b1111, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0010, 1'b0, 4'b1111, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0010, 1'b0, 4'b1111, 4'b0000, 1'b0};
        vecs[3]  = '{4'b0010, 1'b0, 4'b1111, 4'b0000, 1'b0};
        vecs[4]  = '{4'b0010, 1'b0, 4'b1101, 4'b0000, 1'b0};
        vecs[5]  = '{4'b0000, 1'b0, 4'b1101, 4'b0010, 1'b0};
        vecs[6]  = '{4'b0010, 1'b1, 4'b1101, 4'b0010, 1'b1};
        vecs[7]  = '{4'b0000, 1'b1, 4'b1111, 4'b0010, 1'b1};
        vecs[8]  = '{4'b0000, 1'b1, 4'b1111, 4'b0010, 1'b1};
        vecs[9]  = '{4'b0000, 1'b1, 4'b1111, 4'b0010, 1'b1};
        vecs[10] = '{4'b0000, 1'b1, 4'b1111, 4'b0010, 1'b0};

        // Reset state
        #2;
        check("rst_in_rdy", 128'(in_rdy_rr), 128'(4'b0000));
        check("rst_out_ena", 128'(oena_rr), 128'(1'b0));
        check("rst_rule_ready", 128'(rready_rr), 128'(1'b0));
        check("rst_err", 128'(err_rr), 128'(4'b0000));
        check("rst_out_v", 128'(ov_rr), 128'(0));
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_in_rdy_rr", 128'(in_rdy_rr), 128'(4'b1111));
        check("post_rst_in_rdy_fp", 128'(in_rdy_fp), 128'(4'b1111));
        check("post_rst_out_v", 128'(ov_rr), 128'(0));

        // Round-robin fairness: two words on each channel, released together
        ordy_rr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ena_rr = 4'b1111;
            for (int ch = 0; ch < NCHAN; ch++) in_v[ch*WIDTH +: WIDTH] = mk(8'hA0 + 8'(ch), k);
            @(posedge CLK); #1;
        end
        ena_rr = '0;
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < NCHAN; ch++) q_rr.push_back({2'(ch), mk(8'hA0 + 8'(ch), k)});
        ordy_rr = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (oena_rr === 1'b1) cnt++;
        end
        #1;
        check("rr_words_in_8_cycles", 128'(cnt), 128'(8));
        check("rr_queue_drained", 128'(q_rr.size()), 128'(0));

        // Single word on ch2
        @(posedge CLK); #1;
        ena_rr = 4'b0100;
        in_v[2*WIDTH +: WIDTH] = 96'h0A_0000_0001;
        q_rr.push_back({2'd2, 96'h0A_0000_0001});
        @(posedge CLK); #1 ena_rr = '0;
        @(negedge CLK);
        check("single_out_ena", 128'(oena_rr), 128'(1'b1));
        @(negedge CLK);
        check("single_drained_ena", 128'(oena_rr), 128'(1'b0));
        check("single_drained_v", 128'(ov_rr), 128'(0));

        // Backpressure / full FIFO / violation on ch1, table-driven
        for (int r = 0; r < 11; r++) begin
            @(posedge CLK); #1;
            ena_rr  = vecs[r].ena;
            ordy_rr = vecs[r].ordy;
            in_v[1*WIDTH +: WIDTH] = mk(8'hB1, r);
            if (vecs[r].ena[1] && vecs[r].exp_rdy[1]) q_rr.push_back({2'd1, mk(8'hB1, r)});
            @(negedge CLK);
            check($sformatf("bp%0d_in_rdy", r), 128'(in_rdy_rr), 128'(vecs[r].exp_rdy));
            check($sformatf("bp%0d_err", r), 128'(err_rr), 128'(vecs[r].exp_err));
            check($sformatf("bp%0d_out_ena", r), 128'(oena_rr), 128'(vecs[r].exp_ena));
        end
        #1 check("bp_queue_drained", 128'(q_rr.size()), 128'(0));

        // Fixed priority: ch3 waits while ch0 streams for 5 cycles
        @(posedge CLK); #1;
        ena_rr = '0;
        ena_fp = 4'b1001;
        in_v[3*WIDTH +: WIDTH] = mk(8'hD3, 0);
        in_v[0*WIDTH +: WIDTH] = mk(8'hD0, 0);
        for (int k = 0; k < 5; k++) q_fp.push_back({2'd0, mk(8'hD0, k)});
        q_fp.push_back({2'd3, mk(8'hD3, 0)});
        for (int k = 1; k < 5; k++) begin
            @(posedge CLK); #1;
            ena_fp = 4'b0001;
            in_v[0*WIDTH +: WIDTH] = mk(8'hD0, k);
        end
        @(posedge CLK); #1 ena_fp = '0;
        repeat (4) @(negedge CLK);
        #1 check("fp_queue_drained", 128'(q_fp.size()), 128'(0));

        // Wrap-around: 10 words on ch0 with alternating downstream ready
        sent = 0; tog = 1'b0;
        for (int c = 0; c < 80 && (sent < 10 || q_rr.size() != 0); c++) begin
            @(posedge CLK); #1;
            ordy_rr = tog; tog = ~tog;
            if (sent < 10 && in_rdy_rr[0]) begin
                ena_rr = 4'b0001;
                in_v[0*WIDTH +: WIDTH] = mk(8'hE0, sent);
                q_rr.push_back({2'd0, mk(8'hE0, sent)});
                sent++;
            end else begin
                ena_rr = '0;
            end
        end
        ena_rr = '0; ordy_rr = 1'b0;
        check("wrap_words_sent", 128'(sent), 128'(10));
        check("wrap_queue_drained", 128'(q_rr.size()), 128'(0));

        // Reset mid-stream with 3 queued words
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            ena_rr = 4'b0001;
            in_v[0*WIDTH +: WIDTH] = mk(8'hF0, k);
        end
        @(posedge CLK); #1;
        ena_rr = '0; rule_enable = 1'b0; ordy_rr = 1'b1;
        @(negedge CLK);
        check("mid_rule_ready_pre", 128'(rready_rr), 128'(1'b1));
        check("mid_err_pre", 128'(err_rr), 128'(4'b0010));
        #1 nRST = 1'b0; rule_enable = 1'b1;
        #1;
        check("mid_in_rdy", 128'(in_rdy_rr), 128'(4'b0000));
        check("mid_out_ena", 128'(oena_rr), 128'(1'b0));
        check("mid_err", 128'(err_rr), 128'(4'b0000));
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (oena_rr === 1'b1) cnt++;
        end
        check("mid_no_stale_output", 128'(cnt), 128'(0));
        check("mid_in_rdy_after", 128'(in_rdy_rr), 128'(4'b1111));

        #1;
        check("final_rr_queue", 128'(q_rr.size()), 128'(0));
        check("final_fp_queue", 128'(q_fp.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/portal_pipe_mux.md
# portal_pipe_mux

Parametrised N-channel pipe multiplexer. It merges several 96-bit portal pipe streams, such as the `pipe$enq` outputs of indication-output blocks, onto one shared output pipe. Each channel has its own FIFO, and channels are arbitrated in round-robin or fixed-priority order. Each forwarded word is tagged with its channel index, so a downstream demultiplexer can route it to the matching input block.

## Interface
Parameters:
- NCHAN, 4, number of input channels (1..16)
- WIDTH, 96, payload width of one pipe word
- DEPTH, 4, per-channel FIFO depth; power of two, ≥2
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
- ID_W, max(1, clog2(NCHAN)), derived width of the channel tag

Ports:
- CLK  in  1  single clock; all state on the rising edge
- nRST  in  1  asynchronous, active-low reset
- in$enq__ENA  in  NCHAN  per-channel enqueue enable
- in$enq_v  in  NCHAN*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH]
- in$enq__RDY  out  NCHAN  channel i FIFO can accept a word
- out$enq__ENA  out  1  output word valid and consumed this cycle
- out$enq_v  out  ID_W+WIDTH  {channel id, payload}
- out$enq__RDY  in  1  downstream can accept
- rule_enable  in  1  scheduler enable for the internal forward rule
- rule_ready  out  1  forward rule can fire
- err  out  NCHAN  sticky protocol-violation flag per channel

## Operation
- Each channel has a DEPTH-entry FIFO with a read pointer, a write pointer and a count of width clog2(DEPTH)+1.
- in$enq__RDY[i] = nRST && count[i] != DEPTH. The value is registered state only; it has no combinational path from any input.
- Enqueue: when in$enq__ENA[i] && in$enq__RDY[i], the payload is written at wptr[i] and wptr[i] advances modulo DEPTH.
- Violation: when in$enq__ENA[i] && !in$enq__RDY[i], the word is dropped and err[i] is set. err[i] is cleared only by reset.
- Request vector: req[i] = count[i] != 0.
- Forward rule:
  - rule_ready = |req && out$enq__RDY.
  - The rule fires when rule_enable && rule_ready.
  - out$enq__ENA equals the fire condition.
- Grant, PRIO_MODE=0: the first requesting channel found scanning from rr_ptr upward, wrapping modulo NCHAN.
  - On fire, rr_ptr becomes grant+1 modulo NCHAN.
  - rr_ptr does not move when the rule does not fire.
- Grant, PRIO_MODE=1: the lowest-index requesting channel. rr_ptr is unused.
- out$enq_v = {grant[ID_W-1:0], head of the granted FIFO}.
  - The value is combinational from state and is valid whenever |req.
  - When no channel requests, the output is all zeros.
- On fire, the granted FIFO's rptr advances and its count decrements.
- Same-cycle enqueue and dequeue on one channel: count is unchanged and both pointers advance.
- Full FIFO: there is no bypass. in$enq__RDY is low, so an enqueue in the same cycle as a dequeue is a violation, even though a slot frees at that edge.
- Counts never exceed DEPTH and never go below 0.

## Timing
- Reset (nRST low, asynchronous) sets the following immediately, without waiting for CLK:
  - all counts and pointers to 0
  - rr_ptr to 0
  - err to 0
  - in$enq__RDY to 0
  - out$enq__ENA to 0
  - rule_ready to 0
- After reset:
  - in$enq__RDY goes to all ones in the first cycle nRST is high.
  - out$enq_v reads 0 with no requests.
- Reset mid-operation discards all queued words, with no partial output.
- Latency: a word enqueued at edge k can be forwarded, with out$enq__ENA high, in the cycle after edge k. It is consumed at edge k+1. There is no same-cycle input-to-output path.
- Throughput: one word per cycle total across all channels, one enqueue per channel per cycle.
- out$enq__ENA depends combinationally on out$enq__RDY and rule_enable. Downstream must not derive out$enq__RDY from out$enq__ENA.

## Test plan
- Reset, then single word: ch2 enqueues 96'h0A_0000_0001, with out RDY=1 and rule_enable=1.
  - out$enq__ENA=1 in the next cycle.
  - out$enq_v = {2'd2, 96'h0A_0000_0001}.
  - ch2 count returns to 0.
- Round-robin fairness, PRIO_MODE=0: channels 0–3 each hold 2 words.
  - Output order is 0,1,2,3,0,1,2,3.
  - Output is one word per cycle, all 8 words delivered in 8 cycles.
- Fixed priority, PRIO_MODE=1: ch3 holds 1 word, and ch0 is enqueued every cycle for 5 cycles.
  - ch3 is forwarded only after ch0 goes idle.
- Backpressure and full FIFO:
  - With out$enq__RDY=0, after 4 enqueues to ch1, in$enq__RDY[1]=0.
  - A 5th ENA sets err[1]=1, and that word never appears at the output.
  - Releasing RDY yields exactly the 4 words in FIFO order, with err[1] staying 1.
- Wrap-around: 10 words on ch0 with alternating out RDY.
  - The output sequence matches the input sequence exactly, with pointers wrapping twice.
- Reset mid-stream: assert nRST low with 3 words queued.
  - in$enq__RDY, out$enq__ENA and err go to 0 before the next CLK edge.
  - After release, no stale word is output.
